mac_issue_sched: RTL
====================

// Module: mac_issue_sched
// PURPOSE
//  Shares one 16x16 signed MAC datapath (3-stage, falling-edge pipeline) between N requesters.
//  Arbitrates valid/ready requests, drives the MAC instruction/operand inputs, and tracks each
//  issued op through the pipeline with a tag. Routes each result back to its issuer.
//  Sits between requester blocks and the MAC; the MAC instance itself is outside this block.
// PARAMETERS
//  N_REQ    2   number of requesters (2..8)
//  MAC_LAT  3   falling edges from operand issue to valid mac_result; must equal MAC depth
// PORTS
//  clk             in   1        clock; all state updates on falling edge, matching the MAC
//  reset           in   1        asynchronous, active-high reset
//  req_valid       in   N_REQ    request present, one bit per requester
//  req_ready       out  N_REQ    request accepted this cycle (one-hot or zero)
//  req_instr       in   3*N_REQ  per-requester instruction, slice i = [3*i+:3]
//  req_a           in   16*N_REQ per-requester signed multiplier, slice [16*i+:16]
//  req_b           in   16*N_REQ per-requester signed multiplicand, slice [16*i+:16]
//  hold            in   1        blocks new issue; in-flight ops still complete
//  mac_instruction out  3        to MAC instruction
//  mac_multiplier  out  16       to MAC multiplier
//  mac_multiplicand out 16       to MAC multiplicand
//  mac_stall       out  1        to MAC stall; driven = hold
//  mac_result      in   32       from MAC result
//  resp_valid      out  N_REQ    one-hot: result for requester i present this cycle
//  resp_data       out  32       result data, shared across requesters
//  busy            out  1        any tag in flight
// BEHAVIOUR
//  - Reset: tag pipe cleared (all invalid); RR pointer = 0; resp_valid = 0; busy = 0.
//    req_ready forced 0 while reset high. Reset mid-operation discards in-flight tags; no resp issued.
//  - Grant: combinational. Round robin from RR pointer over req_valid; one winner g.
//    req_ready[g] = 1 iff req_valid[g] & ~hold & ~reset. Transfer = valid & ready, sampled on falling edge.
//  - Issue: on transfer, mac_* = requester g's instr/a/b. With no transfer: mac_instruction=3'b000,
//    operands 0.
//  - RR pointer: after transfer by g, pointer <= (g+1) mod N_REQ; unchanged otherwise.
//  - Tag pipe: MAC_LAT stages of {valid, id[$clog2(N_REQ)]}. Each falling edge: stage0 <= {transfer, g};
//    stage k <= stage k-1. Shifts every cycle regardless of hold (MAC has no freeze).
//  - Response: resp_valid[id] = stage[MAC_LAT-1].valid; resp_data = mac_result (passthrough).
//    Latency = MAC_LAT falling edges from transfer. No response backpressure; requesters must accept.
//  - Throughput: one issue per cycle; back-to-back issue from different requesters is allowed.
//  - Hold asserted during a grant: no transfer, pointer unchanged, bubble tag enters stage0.
//  - Single requester active: it wins every cycle. req_valid all 0: bubble.
//  - busy = OR of stage valids.
// CONFIGURATION
//  MAC_SCHED_FIXED_PRIO_EN: defined -> fixed priority, lowest index wins; RR pointer removed.
//  Undefined (default) -> round robin as above.
// STRUCTURE
//  Package mac_pkg: INSTR_W=3, OP_W=16, RES_W=32, MAC_LAT_DEF=3, tag type {valid, id}.
//  Sub-module mac_rr_arbiter (req, ptr -> one-hot grant + index), holds the macro switch.
//  Top holds tag pipe, operand mux, response decode.
// TESTING
//  1. Req0 valid a=3,b=-4 instr=001 -> req_ready[0] same cycle; 3 edges later resp_valid=01,
//     resp_data=32'hFFFFFFF4.
//  2. Both valid continuously, N_REQ=2 -> grants alternate 0,1,0,1; responses alternate 3 edges later.
//  3. hold=1 with both valid for 2 cycles -> req_ready=0, no new resp; in-flight op still returns.
//  4. Issue 3 back-to-back ops, assert reset after 2 edges -> resp_valid stays 0, busy=0, pointer=0.
//  5. a=-32768,b=-32768 -> resp_data=32'h40000000 routed to issuing requester only.
//  6. MAC_SCHED_FIXED_PRIO_EN defined, both valid -> req0 granted every cycle; req1 starved.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared widths and the in-flight tag type for the MAC issue scheduler.
// Optional build macro: MAC_SCHED_FIXED_PRIO_EN (fixed-priority arbitration).
package mac_pkg;

  localparam int INSTR_W     = 3;
  localparam int OP_W        = 16;
  localparam int RES_W       = 32;
  localparam int MAC_LAT_DEF = 3;
  localparam int ID_W        = 3;  // wide enough for up to 8 requesters

  localparam logic [INSTR_W-1:0] INSTR_NOP = '0;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/mac_rr_arbiter.sv
// Request arbiter for the shared MAC: one-hot grant plus winner index, falling-edge pointer.
// MAC_SCHED_FIXED_PRIO_EN defined -> lowest index always wins and the pointer is removed.
module mac_rr_arbiter
  import mac_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req_i,
  input  logic             advance_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  idx_o
);

`ifdef MAC_SCHED_FIXED_PRIO_EN

  logic unused_fixed;
  assign unused_fixed = ^{clk, reset, advance_i};

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    gnt_o = '0;
    idx_o = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        idx_o    = ID_W'(i);
      end
    end
  end

`else

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            found;

  // Search starts at the pointer and wraps; the first requester found wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && req_i[i] && (((int'(ptr_q) + k) % N_REQ) == i)) begin
          found    = 1'b1;
          gnt_o[i] = 1'b1;
          idx_o    = ID_W'(i);
        end
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i) ptr_d = (int'(idx_o) == N_REQ - 1) ? '0 : idx_o + ID_W'(1);
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

`endif

endmodule

// File: rtl/mac_issue_sched.sv
// Issues requester ops onto one shared 16x16 MAC and returns each result to its issuer via a tag pipe.
// Build macro MAC_SCHED_FIXED_PRIO_EN selects fixed priority inside mac_rr_arbiter.
module mac_issue_sched
  import mac_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int MAC_LAT = MAC_LAT_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [INSTR_W*N_REQ-1:0] req_instr,
  input  logic [OP_W*N_REQ-1:0]    req_a,
  input  logic [OP_W*N_REQ-1:0]    req_b,
  input  logic                     hold,
  output logic [INSTR_W-1:0]       mac_instruction,
  output logic [OP_W-1:0]          mac_multiplier,
  output logic [OP_W-1:0]          mac_multiplicand,
  output logic                     mac_stall,
  input  logic [RES_W-1:0]         mac_result,
  output logic [N_REQ-1:0]         resp_valid,
  output logic [RES_W-1:0]         resp_data,
  output logic                     busy
);

  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic             transfer;
  tag_t             pipe_q [MAC_LAT];

  mac_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_i     (req_valid),
    .advance_i (transfer),
    .gnt_o     (gnt),
    .idx_o     (gnt_idx)
  );

  assign req_ready = gnt & {N_REQ{~hold & ~reset}};
  assign transfer  = |req_ready;
  assign mac_stall = hold;
  assign resp_data = mac_result;

  // Idle cycles drive a NOP with zero operands so the MAC never sees stale data.
  always_comb begin
    mac_instruction  = INSTR_NOP;
    mac_multiplier   = '0;
    mac_multiplicand = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_ready[i]) begin
        mac_instruction  = req_instr[INSTR_W*i +: INSTR_W];
        mac_multiplier   = req_a[OP_W*i +: OP_W];
        mac_multiplicand = req_b[OP_W*i +: OP_W];
      end
    end
  end

  // Tag pipe advances every edge, hold or not, because the MAC itself never freezes.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < MAC_LAT; k++) pipe_q[k] <= '0;
    end else begin
      pipe_q[0] <= '{valid: transfer, id: gnt_idx};
      for (int k = 1; k < MAC_LAT; k++) pipe_q[k] <= pipe_q[k-1];
    end
  end

  always_comb begin
    resp_valid = '0;
    for (int i = 0; i < N_REQ; i++)
      resp_valid[i] = pipe_q[MAC_LAT-1].valid && (pipe_q[MAC_LAT-1].id == ID_W'(i));
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < MAC_LAT; k++) busy = busy | pipe_q[k].valid;
  end

endmodule
